// File: rtl/cpu_pkg.sv
// Shared CPU types reused by the renamer and the retire queue.
// Physical register, renamer write-back word and queue entry layouts.
package cpu_pkg;

  localparam int RQ_DEPTH = 8;

  typedef logic [3:0] phys_reg_t;

  typedef struct packed {
    phys_reg_t prev;
    phys_reg_t pnew;
  } wbs_t;

  typedef struct packed {
    logic      valid;
    logic      done;
    phys_reg_t prev;
  } rq_entry_t;

endpackage

// File: rtl/rq_ptr.sv
// Modulo-DEPTH pointer with increment enable.
// Used for both head and tail of the retire queue.
module rq_ptr #(
  parameter int DEPTH = 8,
  parameter int W     = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q, ptr_d;

  // next pointer: wrap explicitly at DEPTH-1
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      ptr_d = (ptr_q == W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  // pointer register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/retire_queue.sv
// In-order retire queue: frees previous physical regs as entries retire.
// Optional RETIRE_QUEUE_STATS_EN adds a 16-bit retired_count output.
module retire_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = RQ_DEPTH,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             alloc_valid,
  input  logic [7:0]       alloc_wbs,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             complete_valid,
  input  logic [TAG_W-1:0] complete_tag,
  output logic [3:0]       retireout,
  output logic             retire_ena_out,
  output logic             empty
`ifdef RETIRE_QUEUE_STATS_EN
  ,
  output logic [15:0]      retired_count
`endif
);

  rq_entry_t        ent_q [DEPTH];
  rq_entry_t        ent_d [DEPTH];
  logic [TAG_W-1:0] head, tail;
  logic [TAG_W:0]   cnt_q, cnt_d;
  logic             ret_vld_q;
  phys_reg_t        ret_reg_q;
  wbs_t             wbs;
  logic             do_alloc, do_ret, do_cmp;
  logic             unused_pnew;

  assign wbs         = alloc_wbs;
  assign unused_pnew = ^wbs.pnew;

  assign alloc_ready = cnt_q < (TAG_W + 1)'(DEPTH);
  assign empty       = (cnt_q == '0);
  assign alloc_tag   = tail;

  assign do_alloc = ena & alloc_valid & alloc_ready;
  assign do_ret   = ena & ent_q[head].valid & ent_q[head].done;
  assign do_cmp   = ena & complete_valid & ent_q[complete_tag].valid;

  rq_ptr #(.DEPTH(DEPTH), .W(TAG_W)) u_head (
    .clk_i  (clk),
    .rst_ni (rst),
    .inc_i  (do_ret),
    .ptr_o  (head)
  );

  rq_ptr #(.DEPTH(DEPTH), .W(TAG_W)) u_tail (
    .clk_i  (clk),
    .rst_ni (rst),
    .inc_i  (do_alloc),
    .ptr_o  (tail)
  );

  // entry updates: complete, then retire clear, then allocate write
  always_comb begin
    ent_d = ent_q;
    if (do_cmp) ent_d[complete_tag].done = 1'b1;
    if (do_ret) ent_d[head] = '0;
    if (do_alloc) begin
      ent_d[tail].valid = 1'b1;
      ent_d[tail].done  = 1'b0;
      ent_d[tail].prev  = wbs.prev;
    end
  end

  // occupancy: count + alloc - retire
  always_comb begin
    cnt_d = cnt_q;
    case ({do_alloc, do_ret})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // queue state; the retire pulse reloads each cycle so it never repeats
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      cnt_q     <= '0;
      ret_vld_q <= 1'b0;
      ret_reg_q <= '0;
    end else begin
      ent_q     <= ent_d;
      cnt_q     <= cnt_d;
      ret_vld_q <= do_ret;
      ret_reg_q <= do_ret ? ent_q[head].prev : '0;
    end
  end

  assign retire_ena_out = ret_vld_q;
  assign retireout      = ret_reg_q;

`ifdef RETIRE_QUEUE_STATS_EN
  logic [15:0] stat_q;

  // retire counter, advances alongside each retire pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        stat_q <= '0;
    else if (do_ret) stat_q <= stat_q + 16'd1;
  end

  assign retired_count = stat_q;
`endif

endmodule

// File: doc/retire_queue.md
RETIRE_QUEUE -- requirements
Module: retire_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of in-flight entries (power of two, 2..16).
REQ-002 SHALL have parameter TAG_W, default 3, width of entry tag, equal to log2(DEPTH).
REQ-003 SHALL have ports clk, input, 1, sole clock; rising-edge only.
REQ-004 SHALL have ports rst, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have ports ena, input, 1, global advance enable; when low, no state changes.
REQ-006 SHALL have ports alloc_valid, input, 1, rename stage presents a renamed write.
REQ-007 SHALL have ports alloc_wbs, input, 8, renamer write-back word: [7:4] previous physical reg, [3:0] new physical reg.
REQ-008 SHALL have ports alloc_ready, output, 1, entry available.
REQ-009 SHALL have ports alloc_tag, output, TAG_W, tag assigned to the current allocation (tail index).
REQ-010 SHALL have ports complete_valid, input, 1, execution result written back.
REQ-011 SHALL have ports complete_tag, input, TAG_W, tag of completed entry.
REQ-012 SHALL have ports retireout, output, 4, physical register to free in the renamer.
REQ-013 SHALL have ports retire_ena_out, output, 1, retireout valid this cycle.
REQ-014 SHALL have ports empty, output, 1, no entries in flight.

Function
REQ-015 SHALL hold entries in program order as a circular buffer with head and tail pointers plus an occupancy count of width TAG_W+1.
- Each entry stores valid, done, and the previous physical reg.
REQ-016 SHALL set alloc_ready = (count < DEPTH), combinationally from registered state only; no same-cycle retire bypass.
REQ-017 SHALL perform an allocation when alloc_valid && alloc_ready && ena.
- Writes entry[tail] = {valid=1, done=0, prev=alloc_wbs[7:4]}.
- Advances tail modulo DEPTH.
- alloc_tag equals tail before the advance.
REQ-018 SHALL ignore alloc_valid while full; the rename stage must hold its request.
REQ-019 SHALL set entry[complete_tag].done on complete_valid && ena, only if that entry is valid.
- Completion of an invalid or already-done entry SHALL be ignored without error.
REQ-020 SHALL retire at most one entry per cycle, in order: when ena && entry[head].valid && entry[head].done, the next cycle presents retire_ena_out=1 and retireout=entry[head].prev.
- Clears entry[head].valid.
- Advances head modulo DEPTH.
REQ-021 SHALL register retireout/retire_ena_out; minimum latency is one cycle from a done bit being set to retire_ena_out (completion at edge N, retire pulse after edge N+1).
REQ-022 SHALL drive retireout=0 whenever retire_ena_out=0.
REQ-023 SHALL handle allocate, complete, and retire in the same cycle independently; count update = count + alloc - retire.
REQ-024 SHALL handle wrap-around of head/tail at DEPTH-1 -> 0 with no lost or duplicated entry.
REQ-025 SHALL set empty = (count == 0).

Reset
REQ-026 SHALL, on rst low (asynchronous), clear head, tail, count, all valid/done bits, retireout=0, retire_ena_out=0; alloc_ready=1, empty=1, alloc_tag=0.
REQ-027 SHALL discard all in-flight entries on reset mid-operation, with no retire pulse emitted for them; release is synchronous to clk.

Configuration
REQ-028 SHALL, with RETIRE_QUEUE_STATS_EN defined, add output retired_count, 16 bits.
- Increments on each retire pulse and wraps at 16'hFFFF -> 0.
- Reset to 0.
REQ-029 SHALL, without RETIRE_QUEUE_STATS_EN, have no retired_count port and no counter logic; all other behaviour identical.

Structure
REQ-030 SHALL place the following in a shared package cpu_pkg, to be reused by the renamer:
- typedef phys_reg_t (4 bits)
- typedef wbs_t (packed {prev, new})
- typedef rq_entry_t (valid, done, prev)
- constant RQ_DEPTH
REQ-031 SHALL keep the queue flat; one sub-module, rq_ptr (modulo-DEPTH pointer with increment enable), is instantiated for head and tail.

Verification
REQ-032 Reset then alloc_wbs=8'h38 -> alloc_tag=0; complete_tag=0 -> one cycle later retire_ena_out=1, retireout=3; empty=1 after.
REQ-033 Allocate tags 0,1,2 (prev 5,6,7); complete 2, then 1, then 0 -> retires in order 5,6,7 on consecutive cycles, none before tag 0 completes.
REQ-034 Fill 8 entries -> alloc_ready=0; 9th alloc_valid held -> no tail change; complete tag 0 -> after retire, alloc_ready=1 and 9th allocates with alloc_tag=0 (wrap).
REQ-035 Same cycle: allocate, complete the head, and retire a done head -> count unchanged, no entry lost; complete_tag pointing at an empty slot -> no effect.
REQ-036 Assert rst low with 4 entries in flight, 2 done -> no retire pulse, empty=1, alloc_tag=0 after release; with RETIRE_QUEUE_STATS_EN, retired_count=0.
